// File: rtl/booth_mul_pkg.sv
// booth_mul_pkg: shared state encoding, default width and Booth op-select for booth_mul
package booth_mul_pkg;
  localparam int W_DEF = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, OUT_LO = 2'd2, OUT_HI = 2'd3} state_t;
  typedef enum logic [1:0] {NOP = 2'd0, ADD = 2'd1, SUB = 2'd2} op_t;
  function automatic op_t booth_op(input logic q0, input logic q_1);
    return ({q0, q_1} == 2'b01) ? ADD : ({q0, q_1} == 2'b10) ? SUB : NOP;
  endfunction
endpackage

// File: rtl/booth_step.sv
// booth_step: one combinational radix-2 Booth step (add/sub then arithmetic shift of {A,Qr,q_1})
module booth_step import booth_mul_pkg::*; #(
  parameter int W = W_DEF
) (
  input  logic [W:0]   a,
  input  logic [W-1:0] qr,
  input  logic         q_1,
  input  logic [W:0]   mr,
  output logic [W:0]   a_nx,
  output logic [W-1:0] qr_nx,
  output logic         q_1_nx
);
  op_t op;
  logic [W:0] sum;
  always_comb begin
    op = booth_op(qr[0], q_1);
    sum = (op == ADD) ? a + mr : (op == SUB) ? a - mr : a;
    {a_nx, qr_nx, q_1_nx} = {sum[W], sum, qr};
  end
endmodule

// File: rtl/booth_mul.sv
// booth_mul: sequential radix-2 Booth multiplier streaming the 2W-bit product as two W-bit beats.
// Optional BOOTH_MUL_DONE_EN adds a one-cycle done pulse after the high beat.
module booth_mul import booth_mul_pkg::*; #(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] M,
  input  logic [W-1:0] Q,
  output logic         busy,
  output logic         out_valid,
  output logic [W-1:0] outbus
`ifdef BOOTH_MUL_DONE_EN
  ,
  output logic         done
`endif
);
  localparam int CW = $clog2(W + 1);
  state_t state, state_nx;
  logic [W:0] a, mr, a_nx;
  logic [W-1:0] qr, qr_nx;
  logic q_1, q_1_nx;
  logic [CW-1:0] cnt;
  booth_step #(.W(W)) u_step (
    .a(a), .qr(qr), .q_1(q_1), .mr(mr),
    .a_nx(a_nx), .qr_nx(qr_nx), .q_1_nx(q_1_nx)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (state == IDLE) ? (start ? CALC : IDLE) :
               (state == CALC) ? ((cnt == CW'(1)) ? OUT_LO : CALC) :
               (state == OUT_LO) ? OUT_HI : IDLE;
  // A and Mr carry an extra sign bit so Mr = -2^(W-1) negates without overflow
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      a <= '0;
      qr <= '0;
      q_1 <= 1'b0;
      mr <= '0;
      cnt <= '0;
    end else if (state == IDLE && start) begin
      a <= '0;
      qr <= Q;
      q_1 <= 1'b0;
      mr <= {M[W-1], M};
      cnt <= CW'(W);
    end else if (state == CALC) begin
      a <= a_nx;
      qr <= qr_nx;
      q_1 <= q_1_nx;
      cnt <= cnt - 1'b1;
    end
  always_comb begin
    busy = (state != IDLE);
    out_valid = (state == OUT_LO) || (state == OUT_HI);
    outbus = (state == OUT_LO) ? qr : (state == OUT_HI) ? a[W-1:0] : '0;
  end
`ifdef BOOTH_MUL_DONE_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) done <= 1'b0;
    else done <= (state == OUT_HI);
`endif
endmodule

// File: tb/tb_booth_mul.sv
// tb_booth_mul: randomized and directed self-checking bench for booth_mul against an integer product model
module tb_booth_mul;
  localparam int W = 8;
  localparam int L = W + 2;
  logic clk = 1'b1;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [W-1:0] M = '0;
  logic [W-1:0] Q = '0;
  logic busy, out_valid;
  logic [W-1:0] outbus;
`ifdef BOOTH_MUL_DONE_EN
  logic done;
`endif
  int checks = 0;
  int errors = 0;

  booth_mul #(.W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .M(M), .Q(Q),
    .busy(busy), .out_valid(out_valid), .outbus(outbus)
`ifdef BOOTH_MUL_DONE_EN
    , .done(done)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [2*W-1:0] prod(input logic [W-1:0] m, input logic [W-1:0] q);
    int mi, qi;
    mi = int'($signed(m));
    qi = int'($signed(q));
    return (2*W)'(mi * qi);
  endfunction

  task automatic do_op(input logic [W-1:0] m, input logic [W-1:0] q, input int ign_at,
                       output logic [W-1:0] lo, output logic [W-1:0] hi,
                       output int nbusy, output int nbeats, output int lo_at, output bit stray);
    int c;
    lo = '0; hi = '0; nbusy = 0; nbeats = 0; lo_at = -1; stray = 1'b0;
    @(negedge clk);
    M = m; Q = q; start = 1'b1;
    @(negedge clk);
    start = 1'b0; M = W'($urandom); Q = W'($urandom);
    c = 0;
    while (busy && c < 40) begin
      if (out_valid) begin
        if (nbeats == 0) begin lo = outbus; lo_at = c; end
        else if (nbeats == 1) hi = outbus;
        nbeats++;
      end else if (outbus !== '0) stray = 1'b1;
      nbusy++;
      c++;
      if (c == ign_at) begin start = 1'b1; M = W'(2); Q = W'(3); end
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    #10;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || outbus !== '0) begin
      errors++; $display("FAIL reset_hold got busy=%b valid=%b bus=%h exp 0/0/00", busy, out_valid, outbus);
    end
`ifdef BOOTH_MUL_DONE_EN
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
`endif
    #15 reset = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || outbus !== '0) begin
      errors++; $display("FAIL reset_release got busy=%b valid=%b bus=%h exp 0/0/00", busy, out_valid, outbus);
    end
  endtask

  task automatic test_products;
    logic [W-1:0] ms[$], qs[$], lo, hi;
    logic [2*W-1:0] exp_p;
    int nbusy, nbeats, lo_at;
    bit stray;
    ms = '{8'd4, 8'hFD, 8'd127, 8'h80, 8'h80, 8'h7F, 8'h00, 8'hFF};
    qs = '{8'd14, 8'd5, 8'hFF, 8'h80, 8'h7F, 8'h80, 8'h80, 8'hFF};
    for (int i = 0; i < 20; i++) begin
      ms.push_back(W'($urandom));
      qs.push_back(W'($urandom));
    end
    foreach (ms[i]) begin
      exp_p = prod(ms[i], qs[i]);
      do_op(ms[i], qs[i], -1, lo, hi, nbusy, nbeats, lo_at, stray);
      checks++; if (lo !== exp_p[W-1:0]) begin errors++; $display("FAIL lo_beat m=%h q=%h got %h exp %h", ms[i], qs[i], lo, exp_p[W-1:0]); end
      checks++; if (hi !== exp_p[2*W-1:W]) begin errors++; $display("FAIL hi_beat m=%h q=%h got %h exp %h", ms[i], qs[i], hi, exp_p[2*W-1:W]); end
      checks++; if (nbusy != L || nbeats != 2 || lo_at != W || stray) begin
        errors++; $display("FAIL timing m=%h q=%h got busy=%0d beats=%0d lo_at=%0d stray=%b exp %0d/2/%0d/0", ms[i], qs[i], nbusy, nbeats, lo_at, stray, L, W);
      end
    end
  endtask

  task automatic test_ignored_start;
    logic [W-1:0] lo, hi;
    int nbusy, nbeats, lo_at;
    bit stray;
    do_op(8'd4, 8'd14, 3, lo, hi, nbusy, nbeats, lo_at, stray);
    checks++; if ({hi, lo} !== prod(8'd4, 8'd14)) begin errors++; $display("FAIL ignored_start_result got %h exp %h", {hi, lo}, prod(8'd4, 8'd14)); end
    checks++; if (nbusy != L || nbeats != 2 || lo_at != W) begin
      errors++; $display("FAIL ignored_start_timing got busy=%0d beats=%0d lo_at=%0d exp %0d/2/%0d", nbusy, nbeats, lo_at, L, W);
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL ignored_start_extra got busy=%b valid=%b exp 0/0", busy, out_valid); end
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] lo, hi;
    int nbusy, nbeats, lo_at;
    bit stray;
    @(negedge clk);
    M = 8'd4; Q = 8'd14; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", busy); end
    #2 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || outbus !== '0) begin
      errors++; $display("FAIL async_reset got busy=%b valid=%b bus=%h exp 0/0/00", busy, out_valid, outbus);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL abort_idle got busy=%b valid=%b exp 0/0", busy, out_valid); end
`ifdef BOOTH_MUL_DONE_EN
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b exp 0", done); end
`endif
    do_op(8'd6, 8'd7, -1, lo, hi, nbusy, nbeats, lo_at, stray);
    checks++; if ({hi, lo} !== prod(8'd6, 8'd7) || nbeats != 2 || nbusy != L) begin
      errors++; $display("FAIL after_abort got %h beats=%0d busy=%0d exp %h/2/%0d", {hi, lo}, nbeats, nbusy, prod(8'd6, 8'd7), L);
    end
  endtask

  task automatic test_back_to_back;
    logic [2*W-1:0] p0, p1;
    logic [W-1:0] exp_o;
    bit exp_b, exp_v;
    p0 = prod(8'd4, 8'd14);
    p1 = prod(8'hFD, 8'd5);
    @(negedge clk);
    M = 8'd4; Q = 8'd14; start = 1'b1;
    @(negedge clk);
    M = 8'hFD; Q = 8'd5;
    for (int c = 0; c < 25; c++) begin
      exp_b = (c < L) || (c >= L + 1 && c < 2 * L + 1);
      exp_v = (c == W) || (c == W + 1) || (c == L + 1 + W) || (c == L + 2 + W);
      exp_o = (c == W) ? p0[W-1:0] : (c == W + 1) ? p0[2*W-1:W] :
              (c == L + 1 + W) ? p1[W-1:0] : (c == L + 2 + W) ? p1[2*W-1:W] : '0;
      checks++; if (busy !== exp_b) begin errors++; $display("FAIL b2b_busy c=%0d got %b exp %b", c, busy, exp_b); end
      checks++; if (out_valid !== exp_v || outbus !== exp_o) begin
        errors++; $display("FAIL b2b_beat c=%0d got valid=%b bus=%h exp %b/%h", c, out_valid, outbus, exp_v, exp_o);
      end
`ifdef BOOTH_MUL_DONE_EN
      checks++; if (done !== (c == L || c == 2 * L + 1)) begin errors++; $display("FAIL b2b_done c=%0d got %b exp %b", c, done, (c == L || c == 2 * L + 1)); end
`endif
      if (c == L + 1) start = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_products();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/booth_mul.md
Name: booth_mul

Overview:
- Sequential radix-2 Booth multiplier. It is the inverse-operation companion to the restoring divider and shares the divider's start/busy/M/Q/outbus handshake.
- Multiplies two W-bit two's-complement operands, one Booth step per clock.
- Streams the 2W-bit product over a W-bit outbus in two beats: low half first, then high half.
- Sits on the same datapath bus as the divider, so the controller can drive either unit with identical sequencing.

Parameters:
- W, 8, operand width and outbus width; product width is 2W.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- start  in  1  request; sampled only in IDLE
- M  in  W  multiplicand, signed; captured on the start edge
- Q  in  W  multiplier, signed; captured on the start edge
- busy  out  1  high in every non-IDLE state
- out_valid  out  1  high while outbus carries a product beat
- outbus  out  W  product beat (low half, then high half); 0 when out_valid=0

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0; out_valid=0; outbus=0; all internal registers cleared. Reset mid-operation aborts with no output beats. Operation resumes on the first clock edge after reset returns to 1.
- Internal registers:
  - A: W+1 bits, sign-extended. The extra bit keeps M = -2^(W-1) correct.
  - Qr: W bits.
  - q_1: 1 bit.
  - Mr: W+1 bits, sign-extended M.
  - cnt: ceil(log2(W+1)) bits.
- IDLE: busy=0. On an edge with start=1: A=0, Qr=Q, q_1=0, Mr=sext(M), cnt=W, go to CALC.
- CALC, one step per edge:
  - {Qr[0],q_1}=01: A=A+Mr.
  - {Qr[0],q_1}=10: A=A-Mr.
  - 00 or 11: A unchanged.
  - Then arithmetic right shift of {A,Qr,q_1} by 1; cnt=cnt-1.
  - On the edge where cnt goes 1→0, go to OUT_LO.
- OUT_LO: out_valid=1, outbus=Qr (product[W-1:0]). Next edge: go to OUT_HI.
- OUT_HI: out_valid=1, outbus=A[W-1:0] (product[2W-1:W]). Next edge: go to IDLE.
- Outputs are decoded from registered state only; no combinational path from inputs to outputs.
- Timing from the start edge E0:
  - busy rises after E0 and stays high for exactly W+2 cycles.
  - Low beat is valid in the cycle after edge E0+W.
  - High beat follows in the next cycle.
  - busy falls after edge E0+W+2.
- start while busy=1 is ignored. M and Q may change freely after E0.
- start held high continuously: a new operation is captured on the first IDLE edge, giving back-to-back operations with one IDLE cycle between them.
- Product is exact for all operand pairs, including (-2^(W-1))×(-2^(W-1)). There is no overflow flag.

Optional Feature:
- Macro: BOOTH_MUL_DONE_EN
- Defined: adds output port done (1 bit). done is a one-cycle pulse, high during the first IDLE cycle after OUT_HI. It is cleared by reset and does not pulse after an aborted operation.
- Undefined: no done port; all other behaviour is identical.

Decomposition:
- Shared package booth_mul_pkg holds:
  - state typedef/constants IDLE=2'd0, CALC=2'd1, OUT_LO=2'd2, OUT_HI=2'd3;
  - default W=8;
  - Booth op-select constants (NOP/ADD/SUB).
- One natural sub-module, booth_step. It is purely combinational: takes A, Qr, q_1, Mr and returns the next {A,Qr,q_1} (add/sub then arithmetic shift). It is instantiated once in the CALC datapath.
- The FSM and counter stay in booth_mul.

Test Plan:
- Basic: reset low 25 ns then high; M=8'd4, Q=8'd14, start pulse → busy high for 10 cycles; beats 0x38 then 0x00 (56).
- Mixed sign: M=-3 (0xFD), Q=5 → beats 0xF1 then 0xFF (-15). Also M=127, Q=-1 → 0x81 then 0xFF.
- Corner: M=Q=0x80 (-128×-128) → 0x00 then 0x40 (16384). Also M=0x80, Q=0x7F → 0x80 then 0xC0 (-16256).
- Ignored start: pulse start with M=2, Q=3 during CALC of a 4×14 operation → result still 0x38/0x00; no extra beats; busy falls on schedule.
- Reset mid-op: assert reset at the 4th CALC cycle → busy, out_valid and outbus go 0 immediately (asynchronously). After release with start=1, M=6, Q=7 → beats 0x2A then 0x00.
- Back-to-back with start held high: 4×14 then -3×5 → exactly one IDLE cycle between the two bursts. With BOOTH_MUL_DONE_EN defined, done pulses once after each burst.
